data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage side of the pipelined MIPS datapath.
- Accepts one load or store request at a time from the memory unit and performs byte, half or word access.
- Returns load data after a fixed wait.
- Drives a stall to the hazard logic while a request is outstanding. Replaces the single-cycle data memory.

Parameters:
- ADDR_W, 10, word-address width; storage is 2^ADDR_W 32-bit words.
- LATENCY, 2, wait cycles between acceptance and response; legal range 1..15.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  request present (MemRead or MemWrite asserted in MEM stage)
- ReqWrite  in  1  1 = store, 0 = load
- LoadStoreByte  in  1  byte access
- LoadStoreHalf  in  1  halfword access
- ReqAddr  in  32  byte address
- ReqWData  in  32  store data; byte/half taken from low bits
- ReqReady  out  1  responder can accept a request
- Stall  out  1  hold the pipeline
- RespValid  out  1  one-cycle response strobe
- RespRData  out  32  load result, sign-extended
- RespErr  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: state=IDLE, wait counter=0, ReqReady=1, Stall=0, RespValid=0, RespRData=0, RespErr=0. Storage contents are not affected by Reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - ReqReady=1.
  - If ReqValid: latch ReqWrite, size, ReqAddr, ReqWData; counter=LATENCY-1; next state WAIT.
- WAIT:
  - ReqReady=0.
  - If counter==0: perform the access on this edge; next state RESP.
  - Otherwise decrement the counter.
- RESP:
  - RespValid=1 for exactly one cycle; next state IDLE.
  - RespRData and RespErr are registered and hold until the next response.
  - ReqReady=0.
- Stall = (state==IDLE & ReqValid) | state==WAIT. Stall is low in RESP so the pipeline advances while capturing RespRData.
- Latency: request sampled in cycle 0, WAIT occupies cycles 1..LATENCY, RespValid in cycle LATENCY+1. Minimum IDLE-to-IDLE occupancy is LATENCY+2 cycles.
- Requests arriving in WAIT or RESP are ignored. The requester holds ReqValid, and it is re-sampled once the responder returns to IDLE.
- Addressing:
  - Word index = ReqAddr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo the memory size.
  - Little-endian lanes: byte lane = ReqAddr[1:0], half lane = ReqAddr[1].
- Size priority: LoadStoreByte over LoadStoreHalf over word.
- Stores:
  - Read-modify-write of the addressed word; only the selected lanes change.
  - RespRData=0 on a store response.
- Loads: byte and half results are sign-extended to 32 bits.
- Reset during WAIT returns to IDLE with no write performed; a pending store is dropped.
- Reset during RESP clears RespValid immediately.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- When defined:
  - A half access with ReqAddr[0]=1, or a word access with ReqAddr[1:0]!=0, is misaligned.
  - Misaligned accesses follow the same timing, set RespErr=1 and RespRData=0, and suppress the write.
- When undefined:
  - The misaligned low address bits are ignored (half uses ReqAddr[1], word uses none).
  - RespErr is tied to 0.

Test Plan:
- Reset, then word store 0xDEADBEEF to 0x10 with LATENCY=2 -> Stall high in cycles 0-2, RespValid in cycle 3; a word load from 0x10 then returns 0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF, byte store 0x55 to 0x11 -> a word load returns 0xDEAD55EF. A byte load from 0x13 returns 0xFFFFFFDE. A half load from 0x12 returns 0xFFFFDEAD.
- ReqValid held high across a complete response -> exactly one RespValid per LATENCY+2 cycles; ReqReady is 0 in WAIT and RESP.
- Reset asserted in the WAIT cycle of a word store 0x12345678 to 0x20 -> outputs return to reset values immediately; a later load from 0x20 returns the old value (0 after an initial clear).
- Word load from 0x14 with ADDR_W=10 -> same data as address 0x1014 (wrap check).
- With DATA_MEM_ALIGN_CHECK_EN: word store to 0x22 -> RespErr=1 and memory unchanged. Without the macro: the same store writes word 0x20 and RespErr=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle MEM-stage data memory: one byte/half/word load or store at a time,
// fixed response latency, stall to the hazard unit while busy. Optional macro: DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic        i_load_store_byte,
  input  logic        i_load_store_half,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_byte;
  logic              r_half;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd_word;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_accept;
  logic              w_access;
  logic              w_misalign;
  logic              w_we;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_merged;
  logic [7:0]        w_lane [4];
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_misalign = !r_byte && (r_half ? r_addr[0] : (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Gate on reset too so a store caught by reset can never reach the array.
  assign w_we = w_access && r_write && !w_misalign && !i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid) w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_byte  <= 1'b0;
      r_half  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY - 1);
        r_write <= i_req_write;
        r_byte  <= i_load_store_byte;
        r_half  <= i_load_store_half;
        r_addr  <= i_req_addr[ADDR_W+1:0];
        r_wdata <= i_req_wdata;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= (r_write || w_misalign) ? 32'd0 : w_load;
        r_err   <= w_misalign;
      end
    end
  end

  // Word is fetched at acceptance; nothing else can write it before the access edge.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[r_addr[ADDR_W+1:2]] <= w_merged;
    end
    if (w_accept) begin
      r_rd_word <= r_mem[i_req_addr[ADDR_W+1:2]];
    end
  end

  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = r_wdata;
    if (r_byte) begin
      w_be     = 4'b0001 << r_addr[1:0];
      w_wlanes = {4{r_wdata[7:0]}};
    end else if (r_half) begin
      w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
      w_wlanes = {2{r_wdata[15:0]}};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = w_be[gi] ? w_wlanes[gi*8 +: 8] : r_rd_word[gi*8 +: 8];
      assign w_lane[gi]          = r_rd_word[gi*8 +: 8];
    end
  endgenerate

  assign w_byte = w_lane[r_addr[1:0]];
  assign w_half = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    w_load = r_rd_word;
    if (r_byte) begin
      w_load = {{24{w_byte[7]}}, w_byte};
    end else if (r_half) begin
      w_load = {{16{w_half[15]}}, w_half};
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_stall      = w_accept || (r_state == S_WAIT);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=10, LATENCY=2): store/load lanes,
// sign extension, held requests, reset mid-access, address wrap and misaligned handling.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        ls_byte = 1'b0;
  logic        ls_half = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_req_valid       (req_valid),
    .i_req_write       (req_write),
    .i_load_store_byte (ls_byte),
    .i_load_store_half (ls_half),
    .i_req_addr        (req_addr),
    .i_req_wdata       (req_wdata),
    .o_req_ready       (req_ready),
    .o_stall           (stall),
    .o_resp_valid      (resp_valid),
    .o_resp_rdata      (resp_rdata),
    .o_resp_err        (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from an IDLE cycle; record per-cycle stall/ready until the response.
  task automatic xact(input logic wr, input logic b, input logic h,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic [7:0] st, output logic [7:0] rdy);
    req_valid = 1'b1; req_write = wr; ls_byte = b; ls_half = h;
    req_addr = addr; req_wdata = wd;
    lat = -1; rd = 'x; er = 1'bx; st = 8'd0; rdy = 8'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      st[c]  = stall;
      rdy[c] = req_ready;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic wr, input logic b, input logic h,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  st;
    logic [7:0]  rdy;
    xact(wr, b, h, addr, wd, rd, er, lat, st, rdy);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  st;
    logic [7:0]  rdy;
    logic [7:0]  rv_hist;
    logic [7:0]  rdy_hist;

    @(negedge clk); @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("clr20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    xact(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, st, rdy);
    chk("sw10_lat", 32'(lat), 32'd3);
    chk("sw10_stall", {24'd0, st}, 32'h07);
    chk("sw10_ready", {24'd0, rdy}, 32'h01);
    chk("sw10_rdata", rd, 32'd0);
    chk("sw10_err", {31'd0, er}, 32'd0);

    run("lw10", 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    run("sb11", 1'b1, 1'b1, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0, 1'b0);
    run("lw10b", 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    run("lb13", 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    run("lb11", 1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 32'h00000055, 1'b0);
    run("lh12", 1'b0, 1'b0, 1'b1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    run("lh10", 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 32'h000055EF, 1'b0);
    run("sh12", 1'b1, 1'b0, 1'b1, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
    run("lw10c", 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    run("sb_prio", 1'b1, 1'b1, 1'b1, 32'h10, 32'h00000077, 32'h0, 1'b0);
    run("lw10d", 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h12345577, 1'b0);

    // ReqValid held across two full transactions
    req_valid = 1'b1; req_write = 1'b0; ls_byte = 1'b0; ls_half = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    rv_hist = 8'd0; rdy_hist = 8'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rv_hist[c]  = resp_valid;
      rdy_hist[c] = req_ready;
    end
    req_valid = 1'b0;
    chk("hold_rvalid", {24'd0, rv_hist}, 32'h88);
    chk("hold_ready", {24'd0, rdy_hist}, 32'h11);
    chk("hold_rdata", resp_rdata, 32'h12345577);
    @(posedge clk); #1;

    // Reset in the first WAIT cycle of a store to 0x20
    req_valid = 1'b1; req_write = 1'b1; ls_byte = 1'b0; ls_half = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run("lw20_after_rst", 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    run("sw1014", 1'b1, 1'b0, 1'b0, 32'h1014, 32'hCAFEF00D, 32'h0, 1'b0);
    run("lw14_wrap", 1'b0, 1'b0, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    run("sw22_mis", 1'b1, 1'b0, 1'b0, 32'h22, 32'h11112222, 32'h0, 1'b1);
    run("lw20_mis", 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    run("lh11_mis", 1'b0, 1'b0, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1);
`else
    run("sw22", 1'b1, 1'b0, 1'b0, 32'h22, 32'h11112222, 32'h0, 1'b0);
    run("lw20", 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0);
    run("lh11", 1'b0, 1'b0, 1'b1, 32'h11, 32'h0, 32'h00005577, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
